// File: rtl/bitbang_pkg.sv
// Shared widths and defaults for the bit-banged configuration receiver.
package bitbang_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [WORD_W-1:0] DEFAULT_CTRL_WORD = 32'h0000FAB1;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  count_t;

endpackage

// File: rtl/bitbang_sync.sv
// N-stage pin synchronizer; with EDGE_EN it also flags rising/falling edges
// of the synchronized level using one extra history flop.
module bitbang_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: non-blocking assignments make every stage take the previous stage's
  // old value, so the chain really is STAGES flops deep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign level_o = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          prev_q <= 1'b0;
        end else begin
          prev_q <= level_o;
        end
      end

      assign rise_o = ~prev_q &  level_o;
      assign fall_o =  prev_q & ~level_o;
    end else begin : g_level
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/bitbang_cfg_rx.sv
// Two-wire bit-banged configuration receiver: data bits on s_clk rise, control
// bits on fall, word committed when the control window matches CTRL_WORD.
// Optional idle flush is built when BITBANG_TIMEOUT_EN is defined.
module bitbang_cfg_rx
  import bitbang_pkg::*;
#(
  parameter logic [WORD_W-1:0] CTRL_WORD      = DEFAULT_CTRL_WORD,
  parameter int                SYNC_STAGES    = 2,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              s_clk,
  input  logic              s_data,
  output logic [WORD_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              active_o,
  output logic [CNT_W-1:0]  word_count_o
);

  logic sclk_rise, sclk_fall, sdata_s;
  logic unused_sclk_level, unused_sdata_rise, unused_sdata_fall;
  logic any_edge;

  // Equal depth on both pins keeps data aligned with the clock edge it belongs to.
  bitbang_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_clk (
    .clk_i   (CLK),
    .rst_i   (reset),
    .async_i (s_clk),
    .level_o (unused_sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  bitbang_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_data (
    .clk_i   (CLK),
    .rst_i   (reset),
    .async_i (s_data),
    .level_o (sdata_s),
    .rise_o  (unused_sdata_rise),
    .fall_o  (unused_sdata_fall)
  );

  assign any_edge = sclk_rise | sclk_fall;

  word_t  data_sr_q, data_sr_d;
  word_t  ctrl_sr_q, ctrl_sr_d;
  word_t  ctrl_nxt;
  word_t  data_q,    data_d;
  logic   valid_q,   valid_d;
  logic   active_q,  active_d;
  count_t count_q,   count_d;
  logic   timeout_hit;

`ifdef BITBANG_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (any_edge) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Stays asserted while saturated; an arriving edge always wins.
  assign timeout_hit = (idle_q == IDLE_MAX) && !any_edge;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  assign ctrl_nxt = {ctrl_sr_q[WORD_W-2:0], sdata_s};

  // NOTE: every _d is given its hold value before any condition so no path
  // through this block can infer a latch.
  always_comb begin
    data_sr_d = data_sr_q;
    ctrl_sr_d = ctrl_sr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    active_d  = active_q;
    count_d   = count_q;

    if (sclk_rise) begin
      data_sr_d = {data_sr_q[WORD_W-2:0], sdata_s};
    end

    if (sclk_fall) begin
      if (ctrl_nxt == CTRL_WORD) begin
        data_d    = data_sr_q;
        valid_d   = 1'b1;
        ctrl_sr_d = '0;
        count_d   = count_q + CNT_W'(1);
      end else begin
        ctrl_sr_d = ctrl_nxt;
      end
    end

    if (any_edge) begin
      active_d = 1'b1;
    end

    if (timeout_hit) begin
      data_sr_d = '0;
      ctrl_sr_d = '0;
      active_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      data_sr_q <= '0;
      ctrl_sr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      data_sr_q <= data_sr_d;
      ctrl_sr_q <= ctrl_sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      count_q   <= count_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign active_o     = active_q;
  assign word_count_o = count_q;

endmodule

// File: tb/tb_bitbang_cfg_rx.sv
// Directed bench for bitbang_cfg_rx: a bit-history model predicts each commit
// and its strobe cycle; a per-cycle compare process checks the outputs.
module tb_bitbang_cfg_rx;

  localparam int          SYNC    = 2;
  localparam int          TIMEOUT = 64;
  localparam logic [31:0] CTRL    = 32'h0000FAB1;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        s_clk = 1'b0;
  logic        s_data = 1'b0;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        active_o;
  logic [15:0] word_count_o;

  bitbang_cfg_rx #(
    .CTRL_WORD      (CTRL),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .s_clk        (s_clk),
    .s_data       (s_data),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .active_o     (active_o),
    .word_count_o (word_count_o)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: complete bit histories since reset; a commit happens when the
  // newest 32 control bits (since the last commit) spell CTRL.
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   m_data_h[$];
  bit   m_ctrl_h[$];

  function automatic logic [31:0] last32(input bit q[$]);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) begin
      int idx = q.size() - 32 + i;
      w = {w[30:0], (idx >= 0) ? q[idx] : 1'b0};
    end
    return w;
  endfunction

  // Compare process: owns rd_idx, the last accepted word and the pulse count.
  int          rd_idx   = 0;
  int          n_pulses = 0;
  logic [31:0] cmp_data = '0;
  logic [15:0] cmp_cnt  = '0;

  always @(negedge CLK) begin
    if (reset) begin
      rd_idx   = exp_q.size();
      cmp_data = '0;
      cmp_cnt  = '0;
    end else if (data_valid_o) begin
      n_pulses++;
      if (rd_idx >= exp_q.size()) begin
        check("unexpected_pulse", 32'(data_valid_o), 32'd0);
      end else begin
        check("pulse_data", data_o, exp_q[rd_idx].data);
        check("pulse_cycle", 32'(cyc), 32'(exp_q[rd_idx].cyc));
        rd_idx++;
        cmp_data = data_o;
        cmp_cnt  = cmp_cnt + 16'd1;
        check("pulse_count", 32'(word_count_o), 32'(cmp_cnt));
      end
    end else begin
      check("hold_data", data_o, cmp_data);
      check("hold_count", 32'(word_count_o), 32'(cmp_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_data_h.delete();
    m_ctrl_h.delete();
    tick(3);
    check("rst_data", data_o, 32'd0);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_active", 32'(active_o), 32'd0);
    check("rst_count", 32'(word_count_o), 32'd0);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic send_pair(input bit d, input bit c);
    s_data = d;
    m_data_h.push_back(d);
    tick(2);
    s_clk = 1'b1;
    tick(2);
    s_data = c;
    tick(2);
    s_clk = 1'b0;
    m_ctrl_h.push_back(c);
    if (m_ctrl_h.size() >= 32 && last32(m_ctrl_h) == CTRL) begin
      exp_q.push_back('{data: last32(m_data_h), cyc: cyc + 1 + SYNC});
      m_ctrl_h.delete();
    end
    tick(2);
  endtask

  task automatic send_bits(input logic [31:0] d, input logic [31:0] c, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_pair(d[i], c[i]);
  endtask

  task automatic idle(input int n);
`ifdef BITBANG_TIMEOUT_EN
    if (n >= TIMEOUT) begin
      m_data_h.delete();
      m_ctrl_h.delete();
    end
`endif
    tick(n);
  endtask

  task automatic drain();
    for (int i = 0; i < 32 && rd_idx < exp_q.size(); i++) tick(1);
    check("drain_all_pulses", 32'(rd_idx), 32'(exp_q.size()));
    tick(6);
  endtask

  int p0;

  initial begin
    tick(2);
    do_reset();

    // single word
    p0 = n_pulses;
    send_bits(32'hDEADBEEF, CTRL, 31, 0);
    drain();
    check("t1_data", data_o, 32'hDEADBEEF);
    check("t1_count", 32'(word_count_o), 32'd1);
    check("t1_pulses", 32'(n_pulses - p0), 32'd1);
    check("t1_active", 32'(active_o), 32'd1);

    // wrong control word
    do_reset();
    p0 = n_pulses;
    send_bits(32'hDEADBEEF, 32'h0000FAB0, 31, 0);
    drain();
    check("t2_data", data_o, 32'd0);
    check("t2_count", 32'(word_count_o), 32'd0);
    check("t2_pulses", 32'(n_pulses - p0), 32'd0);

    // misaligned leading pairs
    do_reset();
    p0 = n_pulses;
    for (int i = 0; i < 5; i++) send_pair(1'($urandom_range(1)), 1'b0);
    send_bits(32'h12345678, CTRL, 31, 0);
    drain();
    check("t3_data", data_o, 32'h12345678);
    check("t3_count", 32'(word_count_o), 32'd1);
    check("t3_pulses", 32'(n_pulses - p0), 32'd1);

    // back-to-back words
    do_reset();
    p0 = n_pulses;
    for (int w = 1; w <= 4; w++) send_bits(32'(w), CTRL, 31, 0);
    drain();
    check("t4_data", data_o, 32'd4);
    check("t4_count", 32'(word_count_o), 32'd4);
    check("t4_pulses", 32'(n_pulses - p0), 32'd4);

    // reset mid-word
    do_reset();
    p0 = n_pulses;
    send_bits(32'h0BADBEEF, CTRL, 31, 16);
    do_reset();
    send_bits(32'hCAFEF00D, CTRL, 31, 0);
    drain();
    check("t5_data", data_o, 32'hCAFEF00D);
    check("t5_count", 32'(word_count_o), 32'd1);
    check("t5_pulses", 32'(n_pulses - p0), 32'd1);

    // idle gap inside a word
    do_reset();
    p0 = n_pulses;
    send_bits(32'h5EC0FFEE, CTRL, 31, 8);
    check("t6_active_before", 32'(active_o), 32'd1);
    idle(90);
`ifdef BITBANG_TIMEOUT_EN
    check("t6_active_gap", 32'(active_o), 32'd0);
`else
    check("t6_active_gap", 32'(active_o), 32'd1);
`endif
    idle(10);
    send_bits(32'h5EC0FFEE, CTRL, 7, 0);
    drain();
`ifdef BITBANG_TIMEOUT_EN
    check("t6_pulses", 32'(n_pulses - p0), 32'd0);
    check("t6_data", data_o, 32'd0);
`else
    check("t6_pulses", 32'(n_pulses - p0), 32'd1);
    check("t6_data", data_o, 32'h5EC0FFEE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
